// File: rtl/lab_nios_system_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
// Ports: address (word address {channel, reg}), chipselect, write_n, writedata, readdata.
// master drives the request side, slave returns readdata one cycle after the address.
interface lab_nios_system_multi_timer_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/lab_nios_system_multi_timer.sv
// Purpose : NUM_CH down-counting interval timers behind an Avalon-MM slave, shared prescaler, ORed irq.
// Latency : reads return registered data 1 cycle after the address; writes take effect on the next edge.
// Backpr. : none, the slave accepts a transfer every cycle (no waitrequest).
// Ports   : clk, reset_n (async active-low), bus (Avalon-MM slave modport), irq,
//           timeout_pulse[NUM_CH-1:0], pwm_out[NUM_CH-1:0] (only with MULTI_TIMER_PWM_EN).
// Option  : define MULTI_TIMER_PWM_EN to add per-channel COMPARE registers at NUM_CH*4+c and pwm_out.
// Map     : channel c at c*4: +0 STATUS {RUN,TO}, +1 CONTROL {STOP,START,CONT,ITO}, +2 PERIOD, +3 SNAPSHOT.
module lab_nios_system_multi_timer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int PRESCALE     = 1,
    parameter int RESET_PERIOD = 49999,
    parameter int ADDR_W       = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    lab_nios_system_multi_timer_if.slave bus,
    output logic                         irq,
    output logic [NUM_CH-1:0]            timeout_pulse
`ifdef MULTI_TIMER_PWM_EN
    ,
    output logic [NUM_CH-1:0]            pwm_out
`endif
);

    localparam int               CH_W    = ADDR_W - 2;
    localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

    logic [ADDR_W-1:0] addr;
    logic [CH_W-1:0]   ch_idx;
    logic [1:0]        reg_sel;
    logic              wr_en;
    logic              tick;
    logic              unused_wdata;

    logic [PS_W-1:0]   presc_q, presc_d;
    logic [31:0]       rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  per_q  [NUM_CH];
    logic [CNT_W-1:0]  per_d  [NUM_CH];
    logic [CNT_W-1:0]  snap_q [NUM_CH];
    logic [CNT_W-1:0]  snap_d [NUM_CH];
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] cont_q, cont_d;
    logic [NUM_CH-1:0] ito_q, ito_d;
    logic [NUM_CH-1:0] to_q, to_d;
    logic [NUM_CH-1:0] fr_q, fr_d;       // force_reload: PERIOD was written last cycle
    logic [NUM_CH-1:0] zero_q, zero_d;   // registered copy of (count == 0) for edge detection
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic [NUM_CH-1:0] wr_ch, ch_hit, is_zero, evt;
`ifdef MULTI_TIMER_PWM_EN
    logic [CNT_W-1:0]  cmp_q  [NUM_CH];
    logic [CNT_W-1:0]  cmp_d  [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [NUM_CH-1:0] cmp_hit;
`endif

    assign addr         = bus.address;
    assign ch_idx       = addr[ADDR_W-1:2];
    assign reg_sel      = addr[1:0];
    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign tick         = (presc_q == PS_W'(PRESCALE - 1));
    assign unused_wdata = ^bus.writedata;

    // Per-channel decode and zero-crossing detection. Channels >= NUM_CH never hit.
    always_comb begin
        ch_hit  = '0;
        wr_ch   = '0;
        is_zero = '0;
        evt     = '0;
`ifdef MULTI_TIMER_PWM_EN
        cmp_hit = '0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            ch_hit[c]  = (int'(ch_idx) == c);
            wr_ch[c]   = wr_en & ch_hit[c];
            is_zero[c] = (cnt_q[c] == '0);
            evt[c]     = is_zero[c] & ~zero_q[c];
`ifdef MULTI_TIMER_PWM_EN
            cmp_hit[c] = (int'(addr) == NUM_CH * 4 + c);
`endif
        end
    end

    always_comb begin
        presc_d = tick ? '0 : presc_q + PS_W'(1);
        rd_d    = '0;
        run_d   = run_q;
        cont_d  = cont_q;
        ito_d   = ito_q;
        fr_d    = '0;
        to_d    = '0;
        zero_d  = is_zero;
        pulse_d = evt;
        cnt_d   = cnt_q;
        per_d   = per_q;
        snap_d  = snap_q;
`ifdef MULTI_TIMER_PWM_EN
        cmp_d   = cmp_q;
        pwm_d   = '0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            // Read mux: CNT_W fields zero-extend, unused bits read 0.
            if (ch_hit[c]) begin
                case (reg_sel)
                    2'd0:    rd_d[1:0]       = {run_q[c], to_q[c]};
                    2'd1:    rd_d[1:0]       = {cont_q[c], ito_q[c]};
                    2'd2:    rd_d[CNT_W-1:0] = per_q[c];
                    default: rd_d[CNT_W-1:0] = snap_q[c];
                endcase
            end

            // A pending reload beats the normal count step.
            if (fr_q[c]) begin
                cnt_d[c] = per_q[c];
            end else if (run_q[c] && tick) begin
                cnt_d[c] = is_zero[c] ? per_q[c] : cnt_q[c] - CNT_W'(1);
            end

            // One-shot expiry and reload both stop the channel; a START write in
            // the same cycle overrides everything, including STOP.
            if ((is_zero[c] && !cont_q[c]) || fr_q[c]) begin
                run_d[c] = 1'b0;
            end
            if (wr_ch[c] && reg_sel == 2'd1) begin
                if (bus.writedata[3]) run_d[c] = 1'b0;
                if (bus.writedata[2]) run_d[c] = 1'b1;
                cont_d[c] = bus.writedata[1];
                ito_d[c]  = bus.writedata[0];
            end

            if (wr_ch[c] && reg_sel == 2'd2) begin
                per_d[c] = bus.writedata[CNT_W-1:0];
                fr_d[c]  = 1'b1;
            end

            if (wr_ch[c] && reg_sel == 2'd3) begin
                snap_d[c] = cnt_q[c];
            end

            // A timeout event in the same cycle as a STATUS write keeps TO set.
            to_d[c] = evt[c] | (to_q[c] & ~(wr_ch[c] && reg_sel == 2'd0));

`ifdef MULTI_TIMER_PWM_EN
            if (cmp_hit[c]) begin
                rd_d[CNT_W-1:0] = cmp_q[c];
                if (wr_en) cmp_d[c] = bus.writedata[CNT_W-1:0];
            end
            pwm_d[c] = run_q[c] & (cnt_q[c] < cmp_q[c]);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            rd_q    <= '0;
            run_q   <= '0;
            cont_q  <= '0;
            ito_q   <= '0;
            to_q    <= '0;
            fr_q    <= '0;
            zero_q  <= {NUM_CH{RST_CNT == '0}};
            pulse_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c]  <= RST_CNT;
                per_q[c]  <= RST_CNT;
                snap_q[c] <= '0;
`ifdef MULTI_TIMER_PWM_EN
                cmp_q[c]  <= '0;
`endif
            end
`ifdef MULTI_TIMER_PWM_EN
            pwm_q   <= '0;
`endif
        end else begin
            presc_q <= presc_d;
            rd_q    <= rd_d;
            run_q   <= run_d;
            cont_q  <= cont_d;
            ito_q   <= ito_d;
            to_q    <= to_d;
            fr_q    <= fr_d;
            zero_q  <= zero_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            snap_q  <= snap_d;
`ifdef MULTI_TIMER_PWM_EN
            cmp_q   <= cmp_d;
            pwm_q   <= pwm_d;
`endif
        end
    end

    assign bus.readdata  = rd_q;
    assign irq           = |(to_q & ito_q);
    assign timeout_pulse = pulse_q;
`ifdef MULTI_TIMER_PWM_EN
    assign pwm_out       = pwm_q;
`endif

endmodule

// File: tb/tb_lab_nios_system_multi_timer.sv
// Bench for lab_nios_system_multi_timer: two instances share one bus stimulus.
// u0: 4 channels, 32-bit, PRESCALE 1. u1: 3 channels, 12-bit (RESET_PERIOD truncates), PRESCALE 4.
// Every cycle both instances are compared against a behavioural model of the register map.
module tb_lab_nios_system_multi_timer;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    lab_nios_system_multi_timer_if #(.ADDR_W(4)) bus0 ();
    lab_nios_system_multi_timer_if #(.ADDR_W(4)) bus1 ();

    logic       irq0, irq1;
    logic [3:0] pulse0;
    logic [2:0] pulse1;
`ifdef MULTI_TIMER_PWM_EN
    logic [3:0] pwm0;
    logic [2:0] pwm1;
`endif

    lab_nios_system_multi_timer #(
        .NUM_CH(4), .CNT_W(32), .PRESCALE(1), .RESET_PERIOD(49999), .ADDR_W(4)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .irq(irq0), .timeout_pulse(pulse0)
`ifdef MULTI_TIMER_PWM_EN
        , .pwm_out(pwm0)
`endif
    );

    lab_nios_system_multi_timer #(
        .NUM_CH(3), .CNT_W(12), .PRESCALE(4), .RESET_PERIOD(49999), .ADDR_W(4)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .irq(irq1), .timeout_pulse(pulse1)
`ifdef MULTI_TIMER_PWM_EN
        , .pwm_out(pwm1)
`endif
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_cnt  [2][4];
    logic [31:0] m_per  [2][4];
    logic [31:0] m_snap [2][4];
    bit          m_run  [2][4];
    bit          m_cont [2][4];
    bit          m_ito  [2][4];
    bit          m_to   [2][4];
    bit          m_fr   [2][4];
    bit          m_zprev[2][4];
    bit          m_pulse[2][4];
    int          m_presc[2];
    logic [31:0] m_rd   [2];

    function automatic int nch(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic int ps(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] cmask(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_0FFF;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_presc[i] = 0;
            m_rd[i]    = 32'h0;
            for (int c = 0; c < 4; c++) begin
                m_cnt[i][c]   = 32'd49999 & cmask(i);
                m_per[i][c]   = 32'd49999 & cmask(i);
                m_snap[i][c]  = 32'h0;
                m_run[i][c]   = 1'b0;
                m_cont[i][c]  = 1'b0;
                m_ito[i][c]   = 1'b0;
                m_to[i][c]    = 1'b0;
                m_fr[i][c]    = 1'b0;
                m_zprev[i][c] = 1'b0;
                m_pulse[i][c] = 1'b0;
            end
        end
    endfunction

    // Advance instance i by one clock edge given this cycle's bus inputs.
    function automatic void model_step(input int i, input int a, input bit cs, input bit wn,
                                       input logic [31:0] wd);
        int          ch;
        int          rg;
        bit          valid;
        bit          we;
        bit          tick;
        logic [31:0] rd;
        ch    = a / 4;
        rg    = a % 4;
        valid = (ch < nch(i));
        we    = cs && !wn && valid;
        tick  = (m_presc[i] == ps(i) - 1);
        rd    = 32'h0;
        if (valid) begin
            case (rg)
                0:       rd = {30'h0, m_run[i][ch], m_to[i][ch]};
                1:       rd = {30'h0, m_cont[i][ch], m_ito[i][ch]};
                2:       rd = m_per[i][ch];
                default: rd = m_snap[i][ch];
            endcase
        end
        m_rd[i]    = rd;
        m_presc[i] = tick ? 0 : m_presc[i] + 1;
        for (int c = 0; c < nch(i); c++) begin
            bit w;
            bit at_zero;
            bit ev;
            w       = we && (ch == c);
            at_zero = (m_cnt[i][c] == 32'h0);
            ev      = at_zero && !m_zprev[i][c];
            if (w && rg == 3) m_snap[i][c] = m_cnt[i][c];
            if (m_fr[i][c])                  m_cnt[i][c] = m_per[i][c];
            else if (m_run[i][c] && tick)    m_cnt[i][c] = at_zero ? m_per[i][c] : m_cnt[i][c] - 32'd1;
            if ((at_zero && !m_cont[i][c]) || m_fr[i][c]) m_run[i][c] = 1'b0;
            if (w && rg == 1) begin
                if (wd[3]) m_run[i][c] = 1'b0;
                if (wd[2]) m_run[i][c] = 1'b1;
                m_cont[i][c] = wd[1];
                m_ito[i][c]  = wd[0];
            end
            m_fr[i][c] = w && (rg == 2);
            if (w && rg == 2) m_per[i][c] = wd & cmask(i);
            m_to[i][c]    = ev || (m_to[i][c] && !(w && rg == 0));
            m_pulse[i][c] = ev;
            m_zprev[i][c] = at_zero;
        end
    endfunction

    function automatic logic [31:0] m_irq(input int i);
        logic [31:0] v;
        v = 32'h0;
        for (int c = 0; c < nch(i); c++) if (m_to[i][c] && m_ito[i][c]) v = 32'h1;
        return v;
    endfunction

    function automatic logic [31:0] m_pvec(input int i);
        logic [31:0] v;
        v = 32'h0;
        for (int c = 0; c < nch(i); c++) v[c] = m_pulse[i][c];
        return v;
    endfunction

    // ---------------- bus driving ----------------
    task automatic cycle(input int a, input bit cs, input bit wn, input logic [31:0] wd);
        bus0.address = 4'(a); bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = wd;
        bus1.address = 4'(a); bus1.chipselect = cs; bus1.write_n = wn; bus1.writedata = wd;
        @(posedge clk);
        model_step(0, a, cs, wn, wd);
        model_step(1, a, cs, wn, wd);
        #1;
        check("rd0",    bus0.readdata,  m_rd[0]);
        check("irq0",   32'(irq0),      m_irq(0));
        check("pulse0", 32'(pulse0),    m_pvec(0));
        check("rd1",    bus1.readdata,  m_rd[1]);
        check("irq1",   32'(irq1),      m_irq(1));
        check("pulse1", 32'(pulse1),    m_pvec(1));
    endtask

    task automatic rd(input int a);
        cycle(a, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cycle(a, 1'b1, 1'b0, d);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd0"},    bus0.readdata, 32'h0);
        check({tag, "_irq0"},   32'(irq0),     32'h0);
        check({tag, "_pulse0"}, 32'(pulse0),   32'h0);
        check({tag, "_rd1"},    bus1.readdata, 32'h0);
        check({tag, "_irq1"},   32'(irq1),     32'h0);
        check({tag, "_pulse1"}, 32'(pulse1),   32'h0);
    endtask

    task automatic do_async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("arst");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    int          np;
    int          k;
    logic [31:0] s1;
    logic [31:0] wd;
    int          a;
    bit          cs;
    bit          wn;

    initial begin
        bus0.address = '0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
        bus1.address = '0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset_n = 1'b1;

        // Reset values through the bus.
        rd(2);
        check("per_rst_u0", bus0.readdata, 32'h0000_C34F);
        check("per_rst_u1", bus1.readdata, 32'h0000_034F);
        rd(0);
        check("status_rst_u0", bus0.readdata, 32'h0);
        check("irq_rst_u0", 32'(irq0), 32'h0);

        // ch1 continuous, period 5 -> one pulse every 6 cycles.
        wr(6, 32'd5);
        wr(5, 32'h7);
        np = 0;
        repeat (24) begin
            rd(4);
            np += int'(pulse0[1]);
        end
        check("ch1_pulses_24cyc", 32'(np), 32'd4);
        check("ch1_irq_set", 32'(irq0), 32'h1);
        wr(4, 32'h0);
        check("ch1_irq_cleared", 32'(irq0), 32'h0);

        // STATUS write landing on the same cycle as a ch1 timeout event.
        k = 0;
        while (!(m_cnt[0][1] == 32'h0 && !m_zprev[0][1]) && k < 20) begin
            rd(4);
            k++;
        end
        if (k >= 20) check("evt_wait_timeout", 32'(k), 32'h0);
        wr(4, 32'h0);
        rd(4);
        check("to_wins_over_clear", 32'(bus0.readdata[0]), 32'h1);
        check("to_wins_irq", 32'(irq0), 32'h1);

        // ch2 one-shot.
        wr(10, 32'd3);
        wr(9, 32'h5);
        np = 0;
        repeat (10) begin
            rd(8);
            np += int'(pulse0[2]);
        end
        check("ch2_oneshot_pulses", 32'(np), 32'd1);
        check("ch2_run_after", 32'(bus0.readdata[1]), 32'h0);
        check("ch2_to_after", 32'(bus0.readdata[0]), 32'h1);
        check("ch2_irq", 32'(irq0), 32'h1);

        // START+STOP together, then a PERIOD write mid-count.
        wr(13, 32'hC);
        rd(12);
        check("ch3_start_wins", 32'(bus0.readdata[1]), 32'h1);
        check("ch3_absent_u1", bus1.readdata, 32'h0);
        wr(14, 32'd7);
        rd(12);
        rd(12);
        check("ch3_run_cleared", 32'(bus0.readdata[1]), 32'h0);
        wr(15, 32'h0);
        rd(15);
        check("ch3_snap_reload", bus0.readdata, 32'd7);

        // u1 ch0 with PRESCALE 4: one step per 4 cycles, period 2 wraps 0 -> 2.
        wr(2, 32'd2);
        wr(1, 32'h6);
        rd(0);
        wr(3, 32'h0);
        rd(3);
        s1 = m_snap[1][0];
        rd(3);
        rd(3);
        wr(3, 32'h0);
        rd(3);
        check("presc_step_u1", bus1.readdata, (s1 == 32'h0) ? 32'd2 : s1 - 32'd1);

        // Randomized traffic with a mid-run asynchronous reset.
        for (int it = 0; it < 2500; it++) begin
            if (it == 1200) do_async_reset();
            a  = int'($urandom_range(0, 15));
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 9) > 3);
            case (a % 4)
                1:       wd = {28'h0, 4'($urandom_range(0, 15))} | (($urandom_range(0, 2) == 0) ? 32'h0 : 32'h4);
                2:       wd = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 9))
                                                          : (($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 9)));
                default: wd = $urandom;
            endcase
            cycle(a, cs, wn, wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
